// File: rtl/branch_commit_unit_pkg.sv
// Shared constants and helpers for the branch commit unit.
package branch_commit_unit_pkg;

   // Default number of queued predictor updates.
   localparam int BCU_FIFO_DEPTH = 4;

   // Fall-through distance for a not-taken branch.
   localparam int PC_STEP = 4;

   // A queued update is {taken, branch_pc}.
   function automatic int bcu_entry_width(input int aw);
      return aw + 1;
   endfunction

   // Pointer width for a power-of-two queue.
   function automatic int bcu_ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/branch_commit_unit_if.sv
// ROB-to-branch-commit-unit bus.
// Handshake: commit_ready_to_rob is driven by the unit from registered state
// and is valid at the start of the cycle. The ROB may raise any
// commit_valid_from_rob bit only in a cycle where commit_ready_to_rob is 1;
// each valid lane in such a cycle is consumed at the rising clock edge.
// Lanes presented while ready is 0 are dropped.
interface branch_commit_unit_if #(parameter int AW = 32);
   logic            commit_ready_to_rob;
   logic [1:0]      commit_valid_from_rob;
   logic [1:0]      is_branch_from_rob;
   logic [2*AW-1:0] pc_from_rob;
   logic [1:0]      predicted_jump_from_rob;
   logic [1:0]      real_jump_from_rob;
   logic [2*AW-1:0] target_pc_from_rob;

   modport master (
      input  commit_ready_to_rob,
      output commit_valid_from_rob, is_branch_from_rob, pc_from_rob,
      output predicted_jump_from_rob, real_jump_from_rob, target_pc_from_rob
   );

   modport slave (
      output commit_ready_to_rob,
      input  commit_valid_from_rob, is_branch_from_rob, pc_from_rob,
      input  predicted_jump_from_rob, real_jump_from_rob, target_pc_from_rob
   );
endinterface

// File: rtl/branch_update_fifo.sv
// Two-write / one-read circular queue of predictor updates.
// wr_en[0] data is older than wr_en[1] data; a lone write lands at the tail.
module branch_update_fifo
   import branch_commit_unit_pkg::*;
#(
   parameter int DEPTH = BCU_FIFO_DEPTH,
   parameter int WIDTH = 33,
   localparam int PW   = bcu_ptr_width(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       wr_en,
   input  logic [WIDTH-1:0] wr_data0,
   input  logic [WIDTH-1:0] wr_data1,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    free_slots,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [1:0]       n_wr;
   logic             pop;

   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign free_slots = CW'(DEPTH) - count_q;
   assign rd_data    = mem_q[rptr_q];

   // Next-state: write up to two entries in order, pop the head on request.
   always_comb begin
      mem_d   = mem_q;
      n_wr    = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
      pop     = rd_en & ~empty;
      if (wr_en[0]) begin
         mem_d[wptr_q] = wr_data0;
      end
      if (wr_en[1]) begin
         mem_d[wr_en[0] ? wptr_q + PW'(1) : wptr_q] = wr_data1;
      end
      wptr_d  = wptr_q + PW'(n_wr);
      rptr_d  = rptr_q + PW'(pop);
      count_d = count_q + CW'(n_wr) - CW'(pop);
   end

   // Storage and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/branch_commit_unit.sv
// Queues committed conditional-branch outcomes from a two-wide ROB, drains one
// update per cycle to the branch predictor, redirects fetch on a mispredict and
// keeps saturating branch / mispredict statistics.
module branch_commit_unit
   import branch_commit_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = BCU_FIFO_DEPTH,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   branch_commit_unit_if.slave   rob,
   output logic                  enable_sign_to_pre,
   output logic                  jump_sign_to_pre,
   output logic [ADDR_WIDTH-1:0] jump_target_pc_to_pre,
   output logic                  rollback_sign_to_fch,
   output logic [ADDR_WIDTH-1:0] rollback_pc_to_fch,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

   localparam int AW = ADDR_WIDTH;
   localparam int EW = bcu_entry_width(AW);
   localparam int FW = bcu_ptr_width(FIFO_DEPTH) + 1;

   logic [AW-1:0] pc0, pc1, tgt0, tgt1;
   logic [1:0]    mis, qual;
   logic          ready, fifo_empty;
   logic [FW-1:0] free_slots, fifo_count;
   logic [EW-1:0] head;

   logic          upd_en_q, upd_en_d, upd_jump_q, upd_jump_d;
   logic [AW-1:0] upd_pc_q, upd_pc_d;
   logic          rb_sign_q, rb_sign_d;
   logic [AW-1:0] rb_pc_q, rb_pc_d;
   logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d, mis_cnt_q, mis_cnt_d;
   logic [CNT_WIDTH:0]   br_sum, mis_sum;
   logic [1:0]           br_inc;

   assign pc0  = rob.pc_from_rob[AW-1:0];
   assign pc1  = rob.pc_from_rob[2*AW-1:AW];
   assign tgt0 = rob.target_pc_from_rob[AW-1:0];
   assign tgt1 = rob.target_pc_from_rob[2*AW-1:AW];

   // Ready comes from registered occupancy, so two writes plus one pop can never overflow.
   assign ready = (free_slots >= FW'(2));
   assign rob.commit_ready_to_rob = ready;

   // Lane qualify; a mispredicting lane 0 squashes the younger lane 1.
   always_comb begin
      mis     = rob.predicted_jump_from_rob ^ rob.real_jump_from_rob;
      qual[0] = rob.commit_valid_from_rob[0] & rob.is_branch_from_rob[0] & ready;
      qual[1] = rob.commit_valid_from_rob[1] & rob.is_branch_from_rob[1] & ready
                & ~(qual[0] & mis[0]);
   end

   branch_update_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst),
      .wr_en      (qual),
      .wr_data0   ({rob.real_jump_from_rob[0], pc0}),
      .wr_data1   ({rob.real_jump_from_rob[1], pc1}),
      .rd_en      (~fifo_empty),
      .rd_data    (head),
      .count      (fifo_count),
      .free_slots (free_slots),
      .empty      (fifo_empty)
   );

   // Predictor update: pop the head whenever the queue holds something.
   always_comb begin
      upd_en_d   = ~fifo_empty;
      upd_jump_d = upd_jump_q;
      upd_pc_d   = upd_pc_q;
      if (!fifo_empty) begin
         upd_jump_d = head[AW];
         upd_pc_d   = head[AW-1:0];
      end
   end

   // Fetch redirect from the oldest qualifying mispredicting lane.
   always_comb begin
      rb_sign_d = 1'b0;
      rb_pc_d   = rb_pc_q;
      if (qual[0] && mis[0]) begin
         rb_sign_d = 1'b1;
         rb_pc_d   = rob.real_jump_from_rob[0] ? tgt0 : pc0 + AW'(PC_STEP);
      end else if (qual[1] && mis[1]) begin
         rb_sign_d = 1'b1;
         rb_pc_d   = rob.real_jump_from_rob[1] ? tgt1 : pc1 + AW'(PC_STEP);
      end
   end

   // Saturating statistics; the carry bit of the widened sum flags saturation.
   always_comb begin
      br_inc       = {1'b0, qual[0]} + {1'b0, qual[1]};
      br_sum       = {1'b0, branch_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, br_inc};
      mis_sum      = {1'b0, mis_cnt_q} + {{CNT_WIDTH{1'b0}}, rb_sign_d};
      branch_cnt_d = br_sum[CNT_WIDTH]  ? '1 : br_sum[CNT_WIDTH-1:0];
      mis_cnt_d    = mis_sum[CNT_WIDTH] ? '1 : mis_sum[CNT_WIDTH-1:0];
   end

   // Output and statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         upd_en_q     <= 1'b0;
         upd_jump_q   <= 1'b0;
         upd_pc_q     <= '0;
         rb_sign_q    <= 1'b0;
         rb_pc_q      <= '0;
         branch_cnt_q <= '0;
         mis_cnt_q    <= '0;
      end else begin
         upd_en_q     <= upd_en_d;
         upd_jump_q   <= upd_jump_d;
         upd_pc_q     <= upd_pc_d;
         rb_sign_q    <= rb_sign_d;
         rb_pc_q      <= rb_pc_d;
         branch_cnt_q <= branch_cnt_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

   assign enable_sign_to_pre    = upd_en_q;
   assign jump_sign_to_pre      = upd_jump_q;
   assign jump_target_pc_to_pre = upd_pc_q;
   assign rollback_sign_to_fch  = rb_sign_q;
   assign rollback_pc_to_fch    = rb_pc_q;
   assign branch_cnt            = branch_cnt_q;
   assign mispredict_cnt        = mis_cnt_q;

endmodule

// File: tb/tb_branch_commit_unit.sv
// Bench for branch_commit_unit: directed scenarios plus randomized commits,
// scored against a transaction-level model (occupancy count, due-cycle queues).
module tb_branch_commit_unit;

   localparam int AW  = 32;
   localparam int FD  = 4;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT ----------------
   branch_commit_unit_if #(.AW(AW)) rob_if ();

   logic          enable_sign_to_pre, jump_sign_to_pre, rollback_sign_to_fch;
   logic [AW-1:0] jump_target_pc_to_pre, rollback_pc_to_fch;
   logic [CW-1:0] branch_cnt, mispredict_cnt;

   branch_commit_unit #(
      .FIFO_DEPTH (FD),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .rob                   (rob_if),
      .enable_sign_to_pre    (enable_sign_to_pre),
      .jump_sign_to_pre      (jump_sign_to_pre),
      .jump_target_pc_to_pre (jump_target_pc_to_pre),
      .rollback_sign_to_fch  (rollback_sign_to_fch),
      .rollback_pc_to_fch    (rollback_pc_to_fch),
      .branch_cnt            (branch_cnt),
      .mispredict_cnt        (mispredict_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [AW:0]   exp_q[$];
   int            due_q[$];
   logic [AW-1:0] rb_q[$];
   int            rb_due_q[$];
   logic [AW:0]   last_upd;
   logic [AW-1:0] last_rb;
   int            last_due;
   int            occ;
   int            exp_br, exp_mis;
   bit            ready_dropped;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_ready();
      return (FD - occ) >= 2;
   endfunction

   function automatic int sat(input int v);
      return (v > MAX) ? MAX : v;
   endfunction

   task automatic model_clear();
      exp_q.delete(); due_q.delete(); rb_q.delete(); rb_due_q.delete();
      last_upd = '0; last_rb = '0; last_due = 0; occ = 0; exp_br = 0; exp_mis = 0;
   endtask

   task automatic set_idle();
      rob_if.commit_valid_from_rob   = '0;
      rob_if.is_branch_from_rob      = '0;
      rob_if.pc_from_rob             = '0;
      rob_if.predicted_jump_from_rob = '0;
      rob_if.real_jump_from_rob      = '0;
      rob_if.target_pc_from_rob      = '0;
   endtask

   // ---------------- driver ----------------
   // One call = one clock cycle. Presents lanes only when the model says ready.
   task automatic drive(input logic [1:0] v, input logic [1:0] br, input logic [1:0] pr,
                        input logic [1:0] rj, input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                        input logic [AW-1:0] t0, input logic [AW-1:0] t1);
      logic [1:0] q, mis;
      logic [AW-1:0] pcs [2];
      logic [AW-1:0] tgts [2];
      bit rdy;
      int nw, due;
      @(negedge clk);
      rdy = model_ready();
      check("ready", rob_if.commit_ready_to_rob, rdy);
      check("branch_cnt", branch_cnt, exp_br);
      check("mispredict_cnt", mispredict_cnt, exp_mis);
      if (!rdy) begin
         v = 2'b00;
         ready_dropped = 1'b1;
      end
      rob_if.commit_valid_from_rob   = v;
      rob_if.is_branch_from_rob      = br;
      rob_if.pc_from_rob             = {p1, p0};
      rob_if.predicted_jump_from_rob = pr;
      rob_if.real_jump_from_rob      = rj;
      rob_if.target_pc_from_rob      = {t1, t0};
      pcs[0] = p0; pcs[1] = p1; tgts[0] = t0; tgts[1] = t1;
      mis  = pr ^ rj;
      q[0] = v[0] & br[0];
      q[1] = v[1] & br[1] & ~(q[0] & mis[0]);
      nw = 0;
      for (int i = 0; i < 2; i++) begin
         if (q[i]) begin
            due = (cyc + 2 > last_due + 1) ? cyc + 2 : last_due + 1;
            exp_q.push_back({rj[i], pcs[i]});
            due_q.push_back(due);
            last_due = due;
            nw++;
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (q[i] && mis[i]) begin
            rb_q.push_back(rj[i] ? tgts[i] : pcs[i] + 32'd4);
            rb_due_q.push_back(cyc + 1);
            exp_mis = sat(exp_mis + 1);
            break;
         end
      end
      exp_br = sat(exp_br + nw);
      occ = occ + nw - ((occ > 0) ? 1 : 0);
      @(posedge clk);
      #1;
      set_idle();
   endtask

   task automatic idle_cycle();
      drive(2'b00, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
   endtask

   // ---------------- monitor ----------------
   logic [AW:0]   mon_e;
   logic [AW-1:0] mon_rb;
   int            mon_d;
   always @(negedge clk) begin
      if (rst) begin
         if (enable_sign_to_pre) begin
            if (exp_q.size() == 0) begin
               check("update_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_d = due_q.pop_front();
               check("update", {jump_sign_to_pre, jump_target_pc_to_pre}, mon_e);
               check("update_cycle", cyc, mon_d);
               last_upd = mon_e;
            end
         end else begin
            check("update_hold", {jump_sign_to_pre, jump_target_pc_to_pre}, last_upd);
         end
         if (rollback_sign_to_fch) begin
            if (rb_q.size() == 0) begin
               check("rollback_unexpected", 1, 0);
            end else begin
               mon_rb = rb_q.pop_front();
               mon_d  = rb_due_q.pop_front();
               check("rollback_pc", rollback_pc_to_fch, mon_rb);
               check("rollback_cycle", cyc, mon_d);
               last_rb = mon_rb;
            end
         end else begin
            check("rollback_hold", rollback_pc_to_fch, last_rb);
         end
      end
   end

   // The ROB side must never present lanes without ready.
   always @(posedge clk) begin
      if (rst && rob_if.commit_valid_from_rob != 2'b00)
         assert (rob_if.commit_ready_to_rob)
         else $error("ROB presented lanes while commit_ready_to_rob=0");
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int accepted;
      logic [1:0] pr;
      model_clear();
      ready_dropped = 1'b0;
      set_idle();

      // 1: reset with lanes toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rob_if.commit_valid_from_rob = 2'($urandom_range(0, 3));
         rob_if.is_branch_from_rob    = 2'($urandom_range(0, 3));
         rob_if.real_jump_from_rob    = 2'($urandom_range(0, 3));
         rob_if.pc_from_rob           = {$urandom(), $urandom()};
         #2;
         check("rst_enable", enable_sign_to_pre, 0);
         check("rst_rollback", rollback_sign_to_fch, 0);
         check("rst_rollback_pc", rollback_pc_to_fch, 0);
         check("rst_target", jump_target_pc_to_pre, 0);
         check("rst_ready", rob_if.commit_ready_to_rob, 1);
         check("rst_counts", {branch_cnt, mispredict_cnt}, 0);
      end
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      idle_cycle();
      check("post_rst_enable_1", enable_sign_to_pre, 0);
      idle_cycle();
      check("post_rst_enable_2", enable_sign_to_pre, 0);

      // 2: lone correctly-predicted taken branch, two-edge latency
      drive(2'b01, 2'b01, 2'b01, 2'b01, 32'h100, 32'h0, 32'h400, 32'h0);
      check("t2_enable_edge1", enable_sign_to_pre, 0);
      check("t2_branch_cnt", branch_cnt, 1);
      check("t2_no_rollback", rollback_sign_to_fch, 0);
      idle_cycle();
      check("t2_enable_edge2", enable_sign_to_pre, 1);
      check("t2_jump", jump_sign_to_pre, 1);
      check("t2_target", jump_target_pc_to_pre, 32'h100);
      idle_cycle();
      check("t2_enable_one_cycle", enable_sign_to_pre, 0);

      // 3: lane 0 mispredict squashes lane 1
      drive(2'b11, 2'b11, 2'b00, 2'b01, 32'h200, 32'h204, 32'h80, 32'h300);
      check("t3_rollback", rollback_sign_to_fch, 1);
      check("t3_rollback_pc", rollback_pc_to_fch, 32'h80);
      check("t3_branch_cnt", branch_cnt, 2);
      check("t3_mispredict_cnt", mispredict_cnt, 1);
      idle_cycle();
      check("t3_rollback_pulse", rollback_sign_to_fch, 0);
      check("t3_update_pc", jump_target_pc_to_pre, 32'h200);
      idle_cycle();
      check("t3_lane1_dropped", enable_sign_to_pre, 0);

      // 4: lane 1 not-taken mispredict at the top of the address space
      drive(2'b10, 2'b10, 2'b10, 2'b00, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h1000);
      check("t4_rollback", rollback_sign_to_fch, 1);
      check("t4_rollback_wrap", rollback_pc_to_fch, 32'h0);
      for (int i = 0; i < 3; i++) idle_cycle();

      // 5: back-to-back dual commits with ready honoured
      accepted = 0;
      for (int i = 0; i < 20 && accepted < 6; i++) begin
         if (model_ready()) accepted++;
         drive(2'b11, 2'b11, 2'b11, 2'b11, 32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8), '0, '0);
      end
      check("t5_six_accepted", accepted, 6);
      check("t5_ready_dropped", ready_dropped, 1);
      for (int i = 0; i < 8; i++) idle_cycle();

      // randomized traffic; counters saturate along the way
      for (int i = 0; i < 200; i++) begin
         pr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            idle_cycle();
         end else begin
            drive(2'($urandom_range(0, 3)),
                  {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                  pr,
                  pr ^ {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
                  $urandom() & ~32'h3, $urandom() & ~32'h3,
                  $urandom() & ~32'h3, $urandom() & ~32'h3);
         end
      end
      for (int i = 0; i < 8; i++) idle_cycle();
      check("branch_cnt_saturated", branch_cnt, MAX);
      check("rand_update_queue_drained", exp_q.size(), 0);

      // 6: reset with three queued and a rollback pending
      drive(2'b11, 2'b11, 2'b00, 2'b00, 32'h500, 32'h504, '0, '0);
      drive(2'b11, 2'b11, 2'b00, 2'b00, 32'h508, 32'h50C, '0, '0);
      @(negedge clk);
      rob_if.commit_valid_from_rob   = 2'b01;
      rob_if.is_branch_from_rob      = 2'b01;
      rob_if.pc_from_rob             = {32'h0, 32'h600};
      rob_if.predicted_jump_from_rob = 2'b00;
      rob_if.real_jump_from_rob      = 2'b01;
      rob_if.target_pc_from_rob      = {32'h0, 32'h700};
      #1;
      rst = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      set_idle();
      check("t6_rst_enable", enable_sign_to_pre, 0);
      check("t6_rst_rollback", rollback_sign_to_fch, 0);
      check("t6_rst_counts", {branch_cnt, mispredict_cnt}, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle_cycle();
         check("t6_no_enable_after_rst", enable_sign_to_pre, 0);
         check("t6_no_rollback_after_rst", rollback_sign_to_fch, 0);
      end

      check("final_update_queue_empty", exp_q.size(), 0);
      check("final_rollback_queue_empty", rb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
